// File: rtl/axis_frame_gen_if.sv
// AXI4-Stream style handshake bundle used by the frame generator and its sink.
interface axis_frame_gen_if;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic        tready;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_frame_gen.sv
// Stream frame generator: emits runs of fixed-length frames (counter, fixed or PRBS-31 payload) with idle gaps.
// Optional feature macro AXIS_FRAME_GEN_PRBS_EN builds the PRBS-31 payload source for mode 2.
//
// state | meaning
// IDLE  | no run active, waiting for cfg_start
// SEND  | presenting words of the current frame
// GAP   | idle cycles between frames, tvalid low
module axis_frame_gen #(
  parameter int U_DLY = 1
) (
  input  logic                axis_clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_stop,
  input  logic [13:0]         cfg_frame_len,
  input  logic [15:0]         cfg_frame_num,
  input  logic [7:0]          cfg_gap,
  input  logic [1:0]          cfg_mode,
  input  logic [31:0]         cfg_fixed_word,
  axis_frame_gen_if.master    m_axis,
  output logic                busy,
  output logic [15:0]         frame_cnt
);

  // Output delay is a simulation-only notion; synthesized registers use zero delay.
  wire unused_u_dly = |U_DLY;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state_q, state_n;
  logic [13:0] len_q, len_n;
  logic [15:0] num_q, num_n;
  logic [7:0]  gap_q, gap_n;
  logic [1:0]  mode_q, mode_n;
  logic [31:0] fixed_q, fixed_n;
  logic [13:0] idx_q, idx_n;
  logic [15:0] fc_q, fc_n;
  logic [7:0]  gap_cnt_q, gap_cnt_n;
  logic        stop_q, stop_n;
  logic        tvalid_q, tvalid_n;
  logic [31:0] tdata_q, tdata_n;
  logic        tlast_q, tlast_n;

  logic        xfer;
  logic        load;
  logic [1:0]  ld_mode;
  logic [31:0] ld_fixed;
  logic [15:0] ld_fc;
  logic [13:0] ld_idx;
  logic [15:0] fc_inc;
  logic        run_done;

`ifdef AXIS_FRAME_GEN_PRBS_EN
  localparam logic [30:0] PRBS_SEED = 31'h7FFF_FFFF;

  logic [30:0] prbs_q, prbs_n;
  logic [30:0] prbs_src;
  logic [31:0] prbs_word;

  // Advance x^31+x^28+1 by 32 steps; first generated bit lands in word bit 31.
  function automatic logic [62:0] prbs_adv(input logic [30:0] s);
    logic [30:0] st;
    logic [31:0] w;
    logic        b;
    st = s;
    w  = '0;
    for (int i = 0; i < 32; i++) begin
      b  = st[30] ^ st[27];
      st = {st[29:0], b};
      w  = {w[30:0], b};
    end
    return {st, w};
  endfunction
`endif

  assign xfer   = tvalid_q & m_axis.tready;
  assign fc_inc = fc_q + 16'd1;

  always_comb begin
    state_n   = state_q;
    len_n     = len_q;
    num_n     = num_q;
    gap_n     = gap_q;
    mode_n    = mode_q;
    fixed_n   = fixed_q;
    idx_n     = idx_q;
    fc_n      = fc_q;
    gap_cnt_n = gap_cnt_q;
    stop_n    = stop_q;
    tvalid_n  = tvalid_q;
    tdata_n   = tdata_q;
    tlast_n   = tlast_q;
    load      = 1'b0;
    ld_fc     = fc_q;
    ld_idx    = 14'd0;
    run_done  = 1'b0;
    ld_mode   = (state_q == IDLE) ? cfg_mode : mode_q;
    ld_fixed  = (state_q == IDLE) ? cfg_fixed_word : fixed_q;

    case (state_q)
      IDLE: begin
        stop_n = 1'b0;
        if (cfg_start && (cfg_frame_len != 14'd0)) begin
          len_n    = cfg_frame_len;
          num_n    = cfg_frame_num;
          gap_n    = cfg_gap;
          mode_n   = cfg_mode;
          fixed_n  = cfg_fixed_word;
          fc_n     = 16'd0;
          idx_n    = 14'd0;
          state_n  = SEND;
          tvalid_n = 1'b1;
          tlast_n  = (cfg_frame_len == 14'd1);
          load     = 1'b1;
          ld_fc    = 16'd0;
        end
      end

      SEND: begin
        if (cfg_stop) stop_n = 1'b1;
        if (xfer) begin
          if (!tlast_q) begin
            idx_n   = idx_q + 14'd1;
            tlast_n = ((idx_q + 14'd1) == (len_q - 14'd1));
            load    = 1'b1;
            ld_idx  = idx_q + 14'd1;
          end else begin
            fc_n     = fc_inc;
            // A stop arriving with the last word still ends the run on this frame.
            run_done = ((num_q != 16'd0) && (fc_inc == num_q)) || stop_q || cfg_stop;
            if (run_done) begin
              state_n  = IDLE;
              stop_n   = 1'b0;
              tvalid_n = 1'b0;
              tlast_n  = 1'b0;
              tdata_n  = 32'd0;
            end else if (gap_q != 8'd0) begin
              state_n   = GAP;
              gap_cnt_n = gap_q;
              tvalid_n  = 1'b0;
              tlast_n   = 1'b0;
              tdata_n   = 32'd0;
            end else begin
              idx_n   = 14'd0;
              tlast_n = (len_q == 14'd1);
              load    = 1'b1;
              ld_fc   = fc_inc;
            end
          end
        end
      end

      GAP: begin
        if (cfg_stop) begin
          state_n = IDLE;
          stop_n  = 1'b0;
        end else if (gap_cnt_q == 8'd1) begin
          state_n  = SEND;
          idx_n    = 14'd0;
          tvalid_n = 1'b1;
          tlast_n  = (len_q == 14'd1);
          load     = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt_q - 8'd1;
        end
      end

      default: begin
        state_n  = IDLE;
        tvalid_n = 1'b0;
        tlast_n  = 1'b0;
        tdata_n  = 32'd0;
      end
    endcase

    if (load) begin
      if (ld_mode == 2'd1) tdata_n = ld_fixed;
      else                 tdata_n = {ld_fc, 2'b00, ld_idx};
    end
  end

`ifdef AXIS_FRAME_GEN_PRBS_EN
  // Each run restarts from the seed; within a run the sequence carries across frames.
  always_comb begin
    prbs_src              = (state_q == IDLE) ? PRBS_SEED : prbs_q;
    {prbs_n, prbs_word}   = prbs_adv(prbs_src);
  end

  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      prbs_q <= PRBS_SEED;
    end else if (load && (ld_mode == 2'd2)) begin
      prbs_q <= prbs_n;
    end
  end
`endif

  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= 14'd0;
      num_q     <= 16'd0;
      gap_q     <= 8'd0;
      mode_q    <= 2'd0;
      fixed_q   <= 32'd0;
      idx_q     <= 14'd0;
      fc_q      <= 16'd0;
      gap_cnt_q <= 8'd0;
      stop_q    <= 1'b0;
      tvalid_q  <= 1'b0;
      tdata_q   <= 32'd0;
      tlast_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      len_q     <= len_n;
      num_q     <= num_n;
      gap_q     <= gap_n;
      mode_q    <= mode_n;
      fixed_q   <= fixed_n;
      idx_q     <= idx_n;
      fc_q      <= fc_n;
      gap_cnt_q <= gap_cnt_n;
      stop_q    <= stop_n;
      tvalid_q  <= tvalid_n;
      tlast_q   <= tlast_n;
`ifdef AXIS_FRAME_GEN_PRBS_EN
      if (load && (ld_mode == 2'd2)) tdata_q <= prbs_word;
      else                           tdata_q <= tdata_n;
`else
      tdata_q   <= tdata_n;
`endif
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tlast  = tlast_q;
  assign busy          = (state_q != IDLE);
  assign frame_cnt     = fc_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Scoreboard bench for axis_frame_gen: stimulus pushes expected words, a monitor pops them on each transfer.
module tb_axis_frame_gen;
  logic        axis_clk = 1'b0;
  logic        rst_n    = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_stop  = 1'b0;
  logic [13:0] cfg_frame_len = '0;
  logic [15:0] cfg_frame_num = '0;
  logic [7:0]  cfg_gap = '0;
  logic [1:0]  cfg_mode = '0;
  logic [31:0] cfg_fixed_word = '0;
  logic        busy;
  logic [15:0] frame_cnt;

  axis_frame_gen_if m_axis();

  axis_frame_gen #(.U_DLY(1)) dut (
    .axis_clk       (axis_clk),
    .rst_n          (rst_n),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .cfg_frame_len  (cfg_frame_len),
    .cfg_frame_num  (cfg_frame_num),
    .cfg_gap        (cfg_gap),
    .cfg_mode       (cfg_mode),
    .cfg_fixed_word (cfg_fixed_word),
    .m_axis         (m_axis),
    .busy           (busy),
    .frame_cnt      (frame_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   gap_cycles = 0;
  int   stall_cnt = 0;
  bit   toggle_en = 1'b0;

`ifdef AXIS_FRAME_GEN_PRBS_EN
  bit hist[$];

  task automatic prbs_seed();
    hist.delete();
    repeat (31) hist.push_back(1'b1);
  endtask

  // Recurrence a[n] = a[n-31] ^ a[n-28], bits packed MSB first.
  task automatic prbs_word(output logic [31:0] w);
    bit b;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      b = hist[0] ^ hist[3];
      void'(hist.pop_front());
      hist.push_back(b);
      w = {w[30:0], b};
    end
  endtask
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic set_cfg(input int len, input int num, input int gap, input int mode, input logic [31:0] fixed);
    cfg_frame_len  = len[13:0];
    cfg_frame_num  = num[15:0];
    cfg_gap        = gap[7:0];
    cfg_mode       = mode[1:0];
    cfg_fixed_word = fixed;
    gap_cycles     = 0;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic push_frame(input int fc, input int len, input int mode, input logic [31:0] fixed);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      if (mode == 1) e.d = fixed;
      else e.d = {fc[15:0], 2'b00, i[13:0]};
`ifdef AXIS_FRAME_GEN_PRBS_EN
      if (mode == 2) prbs_word(e.d);
`endif
      e.l = (i == len - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, busy, 1'b0);
  endtask

  // Toggled tready flips every cycle; otherwise the sink is always ready.
  initial begin
    m_axis.tready = 1'b1;
    forever begin
      @(posedge axis_clk);
      #1;
      m_axis.tready = toggle_en ? ~m_axis.tready : 1'b1;
    end
  end

  initial begin
    bit          stall;
    logic [31:0] pd;
    logic        pl;
    exp_t        e;
    stall = 1'b0;
    pd    = '0;
    pl    = 1'b0;
    forever begin
      @(negedge axis_clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (busy && !m_axis.tvalid) gap_cycles++;
        if (stall) begin
          check("hold_tvalid", m_axis.tvalid, 1'b1);
          check("hold_tdata", m_axis.tdata, pd);
          check("hold_tlast", m_axis.tlast, pl);
        end
        if (m_axis.tvalid && m_axis.tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h with no word expected", m_axis.tdata);
          end else begin
            e = exp_q.pop_front();
            check("word_tdata", m_axis.tdata, e.d);
            check("word_tlast", m_axis.tlast, e.l);
          end
        end
        stall = m_axis.tvalid && !m_axis.tready;
        if (stall) stall_cnt++;
        pd = m_axis.tdata;
        pl = m_axis.tlast;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // reset state
    repeat (3) tick();
    check("rst_tvalid", m_axis.tvalid, 1'b0);
    check("rst_tdata", m_axis.tdata, 32'd0);
    check("rst_tlast", m_axis.tlast, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    rst_n = 1'b1;
    tick();

    // two counter frames with a 3-cycle gap
    set_cfg(4, 2, 3, 0, 32'd0);
    push_frame(0, 4, 0, 0);
    push_frame(1, 4, 0, 0);
    pulse_start();
    check("start_latency_tvalid", m_axis.tvalid, 1'b1);
    check("start_busy", busy, 1'b1);
    wait_idle("two_frames", 200);
    check("two_frames_cnt", frame_cnt, 16'd2);
    check("two_frames_gap", gap_cycles, 3);
    check("two_frames_drained", exp_q.size(), 0);

    // fixed payload under a toggling sink
    set_cfg(8, 1, 0, 1, 32'h0000_5555);
    push_frame(0, 8, 1, 32'h0000_5555);
    stall_cnt = 0;
    toggle_en = 1'b1;
    pulse_start();
    wait_idle("fixed_stall", 200);
    toggle_en = 1'b0;
    tick();
    check("fixed_stall_cnt", frame_cnt, 16'd1);
    check("fixed_stall_seen", (stall_cnt > 0), 1'b1);
    check("fixed_stall_drained", exp_q.size(), 0);

    // continuous back-to-back frames, stop during word 1 of frame 5
    set_cfg(3, 0, 0, 0, 32'd0);
    for (int f = 0; f < 6; f++) push_frame(f, 3, 0, 0);
    pulse_start();
    n = 0;
    while (!(m_axis.tvalid && m_axis.tdata == 32'h0005_0001) && n < 100) begin
      tick();
      n++;
    end
    check("stop_word_found", (n < 100), 1'b1);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    check("stop_busy_last_word", busy, 1'b1);
    tick();
    check("stop_busy_next_cycle", busy, 1'b0);
    check("stop_frame_cnt", frame_cnt, 16'd6);
    check("stop_no_gap", gap_cycles, 0);
    check("stop_drained", exp_q.size(), 0);

    // reset during word 2 of a 16-word frame, then a clean restart
    set_cfg(16, 1, 0, 0, 32'd0);
    push_frame(0, 2, 0, 0);
    exp_q[1].l = 1'b0;
    pulse_start();
    n = 0;
    while (!(m_axis.tvalid && m_axis.tdata == 32'h0000_0002) && n < 50) begin
      tick();
      n++;
    end
    check("rst_mid_word_found", (n < 50), 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_tvalid_async", m_axis.tvalid, 1'b0);
    check("rst_mid_drained", exp_q.size(), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_frame_cnt", frame_cnt, 16'd0);
    push_frame(0, 16, 0, 0);
    pulse_start();
    wait_idle("restart", 200);
    check("restart_cnt", frame_cnt, 16'd1);
    check("restart_drained", exp_q.size(), 0);

    // mode 2: PRBS when built in, counter otherwise
    set_cfg(4, 1, 0, 2, 32'd0);
`ifdef AXIS_FRAME_GEN_PRBS_EN
    prbs_seed();
`endif
    push_frame(0, 4, 2, 0);
    pulse_start();
    wait_idle("mode2", 100);
    check("mode2_drained", exp_q.size(), 0);

    // zero length start is ignored
    set_cfg(0, 1, 0, 0, 32'd0);
    pulse_start();
    check("len0_busy", busy, 1'b0);
    check("len0_tvalid", m_axis.tvalid, 1'b0);
    repeat (3) tick();
    check("len0_busy_later", busy, 1'b0);
    check("len0_tvalid_later", m_axis.tvalid, 1'b0);

    // simultaneous start and stop: start wins, stop discarded
    set_cfg(2, 1, 0, 0, 32'd0);
    push_frame(0, 2, 0, 0);
    cfg_stop = 1'b1;
    pulse_start();
    cfg_stop = 1'b0;
    check("start_stop_busy", busy, 1'b1);
    wait_idle("start_stop", 50);
    check("start_stop_cnt", frame_cnt, 16'd1);
    check("start_stop_drained", exp_q.size(), 0);

    // stop during gap ends the run next cycle; reserved mode 3 acts as counter
    set_cfg(2, 0, 5, 3, 32'hDEAD_BEEF);
    push_frame(0, 2, 3, 0);
    pulse_start();
    n = 0;
    while (!(busy && !m_axis.tvalid) && n < 50) begin
      tick();
      n++;
    end
    check("gap_found", (n < 50), 1'b1);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    check("gap_stop_busy", busy, 1'b0);
    check("gap_stop_cnt", frame_cnt, 16'd1);
    check("gap_stop_drained", exp_q.size(), 0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
